vga_plot_sequencer: RTL and testbench

//  Top-level draw sequencer for the graphing datapath. On start it clears the screen, draws
//  the X and Y axes, then hands the VGA input selector to the function evaluator until the

---
 rtl/vga_plot_sequencer.sv | 156 +++++++++++++++
 tb/tb_vga_plot_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vga_plot_sequencer.sv
// Draw sequencer: clear screen, draw X/Y axes, then hand the VGA
// selector to the function evaluator until the last curve point.
//
// Ports:
//   clk_i, reset_i       clock, async active-high reset
//   start_i              1-cycle redraw request (honoured in IDLE only)
//   func_valid_i         evaluator point valid on selector func inputs
//   func_last_i          qualifies func_valid_i: final curve point
//   func_ready_o         points accepted (FUNC state)
//   load_f_o             selector source: 1 = function, 0 = init channel
//   x_init_o/y_init_o    init-channel coordinates
//   col_init_o           init-channel colour
//   plot_o               VGA write enable, 1 cycle after issue
//   busy_o               high in every state except IDLE
//   done_o               1-cycle pulse when the redraw completes
module vga_plot_sequencer #(
   parameter int               H_RES      = 320,
   parameter int               V_RES      = 240,
   parameter int               X_W        = 9,
   parameter int               Y_W        = 8,
   parameter int               COL_W      = 6,
   parameter logic [COL_W-1:0] BG_COL     = 6'h00,
   parameter logic [COL_W-1:0] AXIS_COL   = 6'h3F,
   parameter int               X_AXIS_ROW = 120,
   parameter int               Y_AXIS_COL = 160
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             func_valid_i,
   input  logic             func_last_i,
   output logic             func_ready_o,
   output logic             load_f_o,
   output logic [X_W-1:0]   x_init_o,
   output logic [Y_W-1:0]   y_init_o,
   output logic [COL_W-1:0] col_init_o,
   output logic             plot_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_AXIS_H,
      S_AXIS_V,
      S_FUNC,
      S_DONE
   } state_e;

   localparam logic [X_W-1:0] X_MAX  = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0] Y_MAX  = Y_W'(V_RES - 1);
   localparam logic [X_W-1:0] X_AXIS = X_W'(Y_AXIS_COL);
   localparam logic [Y_W-1:0] Y_AXIS = Y_W'(X_AXIS_ROW);

   state_e         state_q, state_d;
   logic [X_W-1:0] xc_q, xc_d;
   logic [Y_W-1:0] yc_q, yc_d;
   logic           plot_q;
   logic           issue;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         xc_q    <= '0;
         yc_q    <= '0;
         plot_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         xc_q    <= xc_d;
         yc_q    <= yc_d;
         plot_q  <= issue;
      end
   end

   always_comb begin
      state_d      = state_q;
      xc_d         = xc_q;
      yc_d         = yc_q;
      issue        = 1'b0;
      func_ready_o = 1'b0;
      load_f_o     = 1'b0;
      x_init_o     = '0;
      y_init_o     = '0;
      col_init_o   = '0;
      done_o       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_CLEAR;
               xc_d    = '0;
               yc_d    = '0;
            end
         end
         S_CLEAR: begin
            x_init_o   = xc_q;
            y_init_o   = yc_q;
            col_init_o = BG_COL;
            issue      = 1'b1;
            if (xc_q == X_MAX) begin
               xc_d = '0;
               if (yc_q == Y_MAX) begin
                  yc_d    = '0;
                  state_d = S_AXIS_H;
               end else begin
                  yc_d = yc_q + 1'b1;
               end
            end else begin
               xc_d = xc_q + 1'b1;
            end
         end
         S_AXIS_H: begin
            x_init_o   = xc_q;
            y_init_o   = Y_AXIS;
            col_init_o = AXIS_COL;
            issue      = 1'b1;
            if (xc_q == X_MAX) begin
               xc_d    = '0;
               yc_d    = '0;
               state_d = S_AXIS_V;
            end else begin
               xc_d = xc_q + 1'b1;
            end
         end
         S_AXIS_V: begin
            x_init_o   = X_AXIS;
            y_init_o   = yc_q;
            col_init_o = AXIS_COL;
            issue      = 1'b1;
            if (yc_q == Y_MAX) begin
               yc_d    = '0;
               state_d = S_FUNC;
            end else begin
               yc_d = yc_q + 1'b1;
            end
         end
         S_FUNC: begin
            load_f_o     = 1'b1;
            func_ready_o = 1'b1;
            issue        = func_valid_i;
            if (func_valid_i && func_last_i)
               state_d = S_DONE;
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // plot trails issue by one cycle to line up with the selector register
   assign plot_o = plot_q;
   assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_vga_plot_sequencer.sv
// Directed bench for vga_plot_sequencer on a small 8x4 screen.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vga_plot_sequencer;

   localparam int H  = 8;
   localparam int V  = 4;
   localparam int XA = 2;
   localparam int YA = 3;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       start_i;
   logic       func_valid_i;
   logic       func_last_i;
   logic       func_ready_o;
   logic       load_f_o;
   logic [8:0] x_init_o;
   logic [7:0] y_init_o;
   logic [5:0] col_init_o;
   logic       plot_o;
   logic       busy_o;
   logic       done_o;

   int n_tests = 0;
   int n_fail  = 0;

   vga_plot_sequencer #(
      .H_RES      (H),
      .V_RES      (V),
      .X_AXIS_ROW (XA),
      .Y_AXIS_COL (YA)
   ) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .start_i      (start_i),
      .func_valid_i (func_valid_i),
      .func_last_i  (func_last_i),
      .func_ready_o (func_ready_o),
      .load_f_o     (load_f_o),
      .x_init_o     (x_init_o),
      .y_init_o     (y_init_o),
      .col_init_o   (col_init_o),
      .plot_o       (plot_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Start a redraw and follow CLEAR, AXIS_H, AXIS_V pixel by pixel.
   // Returns positioned at the first FUNC-state falling edge.
   task automatic draw_check(input bit repulse);
      int k;
      k = 0;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            check("clr_x", 32'(x_init_o), 32'(x));
            check("clr_y", 32'(y_init_o), 32'(y));
            check("clr_col", 32'(col_init_o), 32'h00);
            check("clr_busy", 32'(busy_o), 32'd1);
            check("clr_plot", 32'(plot_o), (k > 0) ? 32'd1 : 32'd0);
            check("clr_loadf", 32'(load_f_o), 32'd0);
            start_i = (repulse && k == 10);
            k++;
            @(negedge clk_i);
         end
      end
      start_i = 1'b0;
      for (int x = 0; x < H; x++) begin
         check("axh_x", 32'(x_init_o), 32'(x));
         check("axh_y", 32'(y_init_o), 32'(XA));
         check("axh_col", 32'(col_init_o), 32'h3F);
         check("axh_plot", 32'(plot_o), 32'd1);
         @(negedge clk_i);
      end
      for (int y = 0; y < V; y++) begin
         check("axv_x", 32'(x_init_o), 32'(YA));
         check("axv_y", 32'(y_init_o), 32'(y));
         check("axv_col", 32'(col_init_o), 32'h3F);
         check("axv_plot", 32'(plot_o), 32'd1);
         @(negedge clk_i);
      end
      check("func_loadf", 32'(load_f_o), 32'd1);
      check("func_ready", 32'(func_ready_o), 32'd1);
      check("func_plot0", 32'(plot_o), 32'd1);
      check("func_xinit", 32'(x_init_o), 32'd0);
      check("func_col", 32'(col_init_o), 32'd0);
   endtask

   // Feed points from a valid/last pattern; last entry must be valid+last.
   task automatic func_run(input logic [7:0] vld, input logic [7:0] lst,
                           input int n);
      for (int i = 0; i < n; i++) begin
         check("func_hold_loadf", 32'(load_f_o), 32'd1);
         check("func_hold_done", 32'(done_o), 32'd0);
         func_valid_i = vld[i];
         func_last_i  = lst[i];
         @(negedge clk_i);
         check("func_plot", 32'(plot_o), 32'(vld[i]));
      end
      func_valid_i = 1'b0;
      func_last_i  = 1'b0;
      check("done_pulse", 32'(done_o), 32'd1);
      check("done_loadf", 32'(load_f_o), 32'd0);
      check("done_busy", 32'(busy_o), 32'd1);
      @(negedge clk_i);
      check("idle_done", 32'(done_o), 32'd0);
      check("idle_busy", 32'(busy_o), 32'd0);
      check("idle_plot", 32'(plot_o), 32'd0);
   endtask

   initial begin
      reset_i      = 1'b1;
      start_i      = 1'b0;
      func_valid_i = 1'b0;
      func_last_i  = 1'b0;
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0;

      // idle, no start
      for (int i = 0; i < 10; i++) begin
         check("idle_outs", {28'd0, busy_o, plot_o, load_f_o, done_o}, 32'd0);
         @(negedge clk_i);
      end

      // full redraw: 3 points with gaps, last flagged
      draw_check(1'b0);
      func_run(8'b0010_1001, 8'b0010_0000, 6);

      // start re-pulsed during CLEAR must not disturb the sequence
      draw_check(1'b1);
      func_run(8'b0000_0001, 8'b0000_0001, 1);

      // reset in the middle of AXIS_H
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (H * V + 3) @(negedge clk_i);
      check("pre_rst_busy", 32'(busy_o), 32'd1);
      reset_i = 1'b1;
      #1;
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_plot", 32'(plot_o), 32'd0);
      check("rst_loadf", 32'(load_f_o), 32'd0);
      check("rst_xinit", 32'(x_init_o), 32'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      @(negedge clk_i);
      draw_check(1'b0);
      func_run(8'b0000_0001, 8'b0000_0001, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
